alu_share_arbiter: RTL

- Shares one arithmetic unit among NREQ requesters using round-robin arbitration.
- The unit supports add, multiply, restoring divide and compare.
- Each requester has its own valid/ready request channel and its own valid/ready response channel.
- Sits between the ATM transaction FSMs (balance_check/withdraw/deposit/transfer) and the arithmetic datapath, so that only one multiplier/divider instance is needed.

---
 rtl/alu_share_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one arithmetic unit (add, mul, restoring div, cmp) among NREQ
//   requesters under round-robin arbitration. One transaction runs at a time:
//   grant -> execute -> hold response until the owner consumes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester request pending
//   req_ready  per-requester request accepted (one-hot or zero, combinational)
//   req_op     2-bit opcode per requester: 00 add, 01 mul, 10 div, 11 cmp
//   req_a      WIDTH-bit operand A per requester
//   req_b      WIDTH-bit operand B per requester
//   rsp_valid  per-requester result valid (one-hot or zero)
//   rsp_ready  per-requester result consumed
//   rsp_data   shared 2*WIDTH result bus ({rem,quot} for divide)
//   rsp_div0   divide-by-zero flag, qualified by rsp_valid
//   busy       high whenever the unit is not idle
//   grant_id   index of the requester owning the unit
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic                    rsp_div0,
  output logic                    busy,
  output logic [PTR_W-1:0]        grant_id
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} state_t;

  state_t             state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [WIDTH-1:0]   rem_r, quo_r;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   last_grant;

  // Round-robin search starting just above the last winner, wrapping.
  logic               found;
  logic [PTR_W-1:0]   winner;
  int unsigned        idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_grant) + i) % 32'(NREQ);
      if (!found && req_valid[PTR_W'(idx)]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  // Gated by rst so nothing is accepted while reset is held.
  assign req_ready = (rst && state == IDLE && found) ? (NREQ'(1) << winner) : '0;

  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  always_comb begin
    sel_op = req_op[2*int'(winner) +: 2];
    sel_a  = req_a[WIDTH*int'(winner) +: WIDTH];
    sel_b  = req_b[WIDTH*int'(winner) +: WIDTH];
  end

  // One restoring-division step: quo_r shifts dividend bits out of the top
  // while quotient bits enter at the bottom.
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  always_comb begin
    trial = {rem_r, quo_r[WIDTH-1]};
    if (trial >= {1'b0, b_r}) begin
      qbit   = 1'b1;
      rem_nx = WIDTH'(trial - {1'b0, b_r});
    end else begin
      qbit   = 1'b0;
      rem_nx = trial[WIDTH-1:0];
    end
    quo_nx = WIDTH'({quo_r, qbit});
  end

  // Single-cycle results; the div entry only occurs for b == 0.
  logic [2*WIDTH-1:0] exec_res;

  always_comb begin
    exec_res = '0;
    case (op_r)
      2'b00: exec_res = (2*WIDTH)'(a_r) + (2*WIDTH)'(b_r);
      2'b01: exec_res = (2*WIDTH)'(a_r) * (2*WIDTH)'(b_r);
      2'b10: exec_res = {a_r, {WIDTH{1'b1}}};
      default: begin
        exec_res[0] = (a_r == b_r);
        exec_res[1] = (a_r > b_r);
        exec_res[2] = (a_r < b_r);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      cnt        <= '0;
      last_grant <= PTR_W'(NREQ - 1);
      grant_id   <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_div0   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_r       <= sel_op;
            a_r        <= sel_a;
            b_r        <= sel_b;
            grant_id   <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
            cnt        <= '0;
            rem_r      <= '0;
            quo_r      <= sel_a;
            state      <= (sel_op == 2'b10 && sel_b != '0) ? DIV : EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= exec_res;
          rsp_div0  <= (op_r == 2'b10);
          rsp_valid <= NREQ'(1) << grant_id;
          state     <= RESP;
        end
        DIV: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            rsp_data  <= {rem_nx, quo_nx};
            rsp_div0  <= 1'b0;
            rsp_valid <= NREQ'(1) << grant_id;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            rsp_div0  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
